// File: rtl/rem_sched.sv
// rem_sched: two-port round-robin scheduler for an iterative-subtraction remainder unit.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready[1:0] per-port job handshake (req_ready combinational)
//   req_num0/req_den0        operands from port 0
//   req_num1/req_den1        operands from port 1
//   rsp_valid/rsp_ready[1:0] per-port result handshake (rsp_valid one-hot or zero)
//   rsp_rem, rsp_dbz         remainder and divide-by-zero flag
//   busy                     high while a job is held (CALC or DONE)
//   dbz_count                divide-by-zero event counter, live only with REM_SCHED_DBZ_CNT_EN
module rem_sched #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_num0,
  input  logic [WIDTH-1:0] req_den0,
  input  logic [WIDTH-1:0] req_num1,
  input  logic [WIDTH-1:0] req_den1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_rem,
  output logic             rsp_dbz,
  output logic             busy,
  output logic [7:0]       dbz_count
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx, den, den_nx, rem_nx, sel_num, sel_den;
  logic dbz_nx, owner, owner_nx, rr, rr_nx, grant;
  // rr only breaks ties; a lone requester always wins
  always_comb begin
    grant = &req_valid ? rr : req_valid[1];
    sel_num = grant ? req_num1 : req_num0;
    sel_den = grant ? req_den1 : req_den0;
    req_ready = 2'b00;
    state_nx = state;
    acc_nx = acc;
    den_nx = den;
    rem_nx = rsp_rem;
    dbz_nx = rsp_dbz;
    owner_nx = owner;
    rr_nx = rr;
    case (state)
      IDLE: begin
        req_ready = req_valid & (grant ? 2'b10 : 2'b01);
        if (|req_ready) begin
          owner_nx = grant;
          acc_nx = sel_num;
          den_nx = sel_den;
          dbz_nx = sel_den == '0;
          rem_nx = sel_den == '0 ? sel_num : rsp_rem;
          state_nx = sel_den == '0 ? DONE : CALC;
        end
      end
      CALC: begin
        if (acc >= den) acc_nx = acc - den;
        else begin
          rem_nx = acc;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (rsp_ready[owner]) begin
          state_nx = IDLE;
          rr_nx = ~owner;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      den <= '0;
      rsp_rem <= '0;
      rsp_dbz <= 1'b0;
      owner <= 1'b0;
      rr <= 1'b0;
    end else begin
      state <= state_nx;
      acc <= acc_nx;
      den <= den_nx;
      rsp_rem <= rem_nx;
      rsp_dbz <= dbz_nx;
      owner <= owner_nx;
      rr <= rr_nx;
    end
  end
  assign rsp_valid = state == DONE ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy = state != IDLE;
`ifdef REM_SCHED_DBZ_CNT_EN
  logic dbz_hit;
  assign dbz_hit = |req_ready && sel_den == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbz_count <= 8'h00;
    else if (dbz_hit && dbz_count != 8'hFF) dbz_count <= dbz_count + 8'd1;
  end
`else
  assign dbz_count = 8'h00;
`endif
endmodule

// File: tb/tb_rem_sched.sv
// tb_rem_sched: scoreboard bench for rem_sched (handshakes, arbitration, hold, reset abort, sweep).
module tb_rem_sched;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2:0] num0, den0, num1, den1, rsp_rem;
  logic rsp_dbz, busy;
  logic [7:0] dbz_count;
  typedef struct {int port; int rem; int dbz; int lat;} exp_t;
  exp_t sb[$];
  int grants[$];
  int total = 0, bad = 0, cyc = 0, acc_edge = 0, exp_cnt = 0, rv_seen = 0;
  logic prev_v = 1'b0;
  rem_sched #(.WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_num0(num0), .req_den0(den0), .req_num1(num1), .req_den1(den1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rem(rsp_rem),
    .rsp_dbz(rsp_dbz), .busy(busy), .dbz_count(dbz_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  // model of each accepted job, built from the operands presented at the accepting edge
  always @(negedge clk) begin
    if (!rst_n) prev_v = 1'b0;
    else begin
      if (|rsp_valid) rv_seen++;
      if (|req_ready) begin
        automatic int p = req_ready[1] ? 1 : 0;
        automatic int n = p ? int'(num1) : int'(num0);
        automatic int d = p ? int'(den1) : int'(den0);
        exp_t e;
        e.port = p;
        e.rem = d == 0 ? n : n % d;
        e.dbz = d == 0 ? 1 : 0;
        e.lat = d == 0 ? 0 : n / d + 1;
        sb.push_back(e);
        grants.push_back(p);
        acc_edge = cyc + 1;
        if (d == 0 && exp_cnt != 255) begin
`ifdef REM_SCHED_DBZ_CNT_EN
          exp_cnt++;
`endif
        end
      end
      if (|rsp_valid && !prev_v) begin
        if (sb.size() == 0) chk("spurious_rsp", 1, 0);
        else chk("latency", cyc - acc_edge, sb[0].lat);
      end
      if (|(rsp_valid & rsp_ready) && sb.size() != 0) begin
        automatic exp_t e = sb.pop_front();
        chk("rsp_port", int'(rsp_valid), e.port ? 2 : 1);
        chk("rsp_rem", int'(rsp_rem), e.rem);
        chk("rsp_dbz", int'(rsp_dbz), e.dbz);
      end
      prev_v = |rsp_valid;
    end
  end
  task automatic send(input int p, input logic [2:0] n, input logic [2:0] d);
    int t = 0;
    if (p == 0) begin num0 = n; den0 = d; end
    else begin num1 = n; den1 = d; end
    req_valid[p] = 1'b1;
    #0;
    while (!req_ready[p] && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) chk("drain_timeout", 1, 0);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_rem"}, int'(rsp_rem), 0);
    chk({tag, "_rsp_dbz"}, int'(rsp_dbz), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_dbz_count"}, int'(dbz_count), 0);
  endtask
  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    {num0, den0, num1, den1} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    chk("reset_req_ready", int'(req_ready), 0);
    rst_n = 1'b1;
    send(0, 3'd7, 3'd2);
    drain();
    send(1, 3'd5, 3'd0);
    drain();
    chk("dbz_count_after_dbz", int'(dbz_count), exp_cnt);
    // both ports held valid: grants must alternate starting with port 0
    grants.delete();
    num0 = 3'd6; den0 = 3'd4; num1 = 3'd3; den1 = 3'd3;
    req_valid = 2'b11;
    for (int t = 0; t < 200 && grants.size() < 4; t++) begin
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    drain();
    chk("grant_count", grants.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("grant%0d", i), grants.size() > i ? grants[i] : -1, i % 2);
    // response stall: non-owner ready is ignored and a waiting requester sees no ready
    rsp_ready = 2'b10;
    send(0, 3'd6, 3'd4);
    num1 = 3'd1; den1 = 3'd1;
    req_valid[1] = 1'b1;
    for (int t = 0; t < 50 && rsp_valid == 2'b00; t++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", int'(rsp_valid), 1);
      chk("hold_rsp_rem", int'(rsp_rem), 2);
      chk("hold_rsp_dbz", int'(rsp_dbz), 0);
      chk("hold_req_ready", int'(req_ready), 0);
    end
    rsp_ready = 2'b11;
    send(1, 3'd1, 3'd1);
    drain();
    // reset during CALC aborts the job without a response
    send(0, 3'd7, 3'd1);
    @(posedge clk); #2;
    chk("pre_abort_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset("abort");
    sb.delete();
    exp_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rv_seen = 0;
    repeat (15) @(posedge clk);
    #1;
    chk("no_rsp_after_abort", rv_seen, 0);
    chk("idle_after_abort", int'(busy), 0);
    for (int n = 0; n < 8; n++)
      for (int d = 0; d < 8; d++) begin
        send(0, 3'(n), 3'(d));
        drain();
      end
    chk("dbz_count_final", int'(dbz_count), exp_cnt);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
